// File: rtl/task_scheduler_if.sv
// ----------------------------------------------------------------------------
// task_scheduler_if
//   Groups the control-register and task-manager signals of task_scheduler.
//   master : scheduler view (drives o_*, receives i_*)
//   slave  : environment view (control block + task manager)
//   Signals:
//     i_go            start a run (sampled in IDLE only)
//     i_abort         abandon the run in progress
//     i_enabled_tasks bit k-1 = task k enabled
//     i_tasks_done    task manager done flag (sticky until o_tm_rst)
//     o_tm_rst        reset to the task manager
//     o_current_task  task number granted, 0 = none
//     o_start_tests   one-cycle start pulse
//     o_busy          scheduler not idle
//     o_run_done      one-cycle end-of-run pulse
//     o_aborted       last run ended by i_abort
//     o_done_mask     bit k-1 set when task k completed
//     o_timeout_mask  bit k-1 set when task k timed out
// ----------------------------------------------------------------------------
interface task_scheduler_if;
   logic        i_go;
   logic        i_abort;
   logic [31:0] i_enabled_tasks;
   logic        i_tasks_done;
   logic        o_tm_rst;
   logic [31:0] o_current_task;
   logic        o_start_tests;
   logic        o_busy;
   logic        o_run_done;
   logic        o_aborted;
   logic [31:0] o_done_mask;
   logic [31:0] o_timeout_mask;

   modport master (
      input  i_go,
      input  i_abort,
      input  i_enabled_tasks,
      input  i_tasks_done,
      output o_tm_rst,
      output o_current_task,
      output o_start_tests,
      output o_busy,
      output o_run_done,
      output o_aborted,
      output o_done_mask,
      output o_timeout_mask
   );

   modport slave (
      output i_go,
      output i_abort,
      output i_enabled_tasks,
      output i_tasks_done,
      input  o_tm_rst,
      input  o_current_task,
      input  o_start_tests,
      input  o_busy,
      input  o_run_done,
      input  o_aborted,
      input  o_done_mask,
      input  o_timeout_mask
   );
endinterface : task_scheduler_if

// File: rtl/task_scheduler.sv
// ----------------------------------------------------------------------------
// task_scheduler
//   Walks the task manager through every enabled task of a test run: for each
//   enabled task it resets the task manager, grants the task number, pulses
//   start and waits for done or a timeout, recording per-task done/timeout
//   masks for software. Sits between the control register block and the task
//   manager.
//   Ports:
//     i_clk  clock
//     i_rst  synchronous, active-high reset
//     bus    task_scheduler_if.master (go/abort/enables/done in; task-manager
//            controls, status and result masks out)
//   Parameters:
//     NUMBER_OF_TASKS  highest task index scanned (1..NUMBER_OF_TASKS, <=32)
//     TM_RST_CYCLES    cycles o_tm_rst is held before each task (>=1)
//     TIMEOUT_CYCLES   max WAIT_DONE cycles per task (>=2)
//     TIMEOUT_W        timer width, 2**TIMEOUT_W > TIMEOUT_CYCLES
// ----------------------------------------------------------------------------
module task_scheduler #(
   parameter int unsigned NUMBER_OF_TASKS = 16,
   parameter int unsigned TM_RST_CYCLES   = 4,
   parameter int unsigned TIMEOUT_CYCLES  = 100000,
   parameter int unsigned TIMEOUT_W       = 20
) (
   input  logic               i_clk,
   input  logic               i_rst,
   task_scheduler_if.master   bus
);

   localparam int unsigned IDX_W  = 6;
   localparam int unsigned SEL_W  = 5;
   localparam int unsigned TASK_W = 32;
   localparam int unsigned RST_W  = (TM_RST_CYCLES > 1) ? $clog2(TM_RST_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCAN,
      S_TM_RESET,
      S_START,
      S_WAIT_DONE,
      S_NEXT,
      S_FINISH
   } state_e;

   // State and datapath registers
   state_e              state_q,        state_d;
   logic [IDX_W-1:0]    idx_q,          idx_d;
   logic [TIMEOUT_W-1:0] timer_q,       timer_d;
   logic [RST_W-1:0]    rst_cnt_q,      rst_cnt_d;
   logic [TASK_W-1:0]   done_mask_q,    done_mask_d;
   logic [TASK_W-1:0]   timeout_mask_q, timeout_mask_d;
   logic                aborted_q,      aborted_d;

   // Registered outputs
   logic                tm_rst_q,       tm_rst_d;
   logic [TASK_W-1:0]   cur_task_q,     cur_task_d;
   logic                start_q,        start_d;
   logic                busy_q,         busy_d;
   logic                run_done_q,     run_done_d;

   // Mask bit of the task under idx; only meaningful while idx is 1..NUMBER_OF_TASKS
   logic [SEL_W-1:0]    bit_sel;
   logic                abort_ok;

   assign bit_sel  = SEL_W'(idx_q - IDX_W'(1));
   assign abort_ok = bus.i_abort && (state_q != S_IDLE) && (state_q != S_FINISH);

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q        <= S_IDLE;
         idx_q          <= '0;
         timer_q        <= '0;
         rst_cnt_q      <= '0;
         done_mask_q    <= '0;
         timeout_mask_q <= '0;
         aborted_q      <= 1'b0;
         tm_rst_q       <= 1'b0;
         cur_task_q     <= '0;
         start_q        <= 1'b0;
         busy_q         <= 1'b0;
         run_done_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         timer_q        <= timer_d;
         rst_cnt_q      <= rst_cnt_d;
         done_mask_q    <= done_mask_d;
         timeout_mask_q <= timeout_mask_d;
         aborted_q      <= aborted_d;
         tm_rst_q       <= tm_rst_d;
         cur_task_q     <= cur_task_d;
         start_q        <= start_d;
         busy_q         <= busy_d;
         run_done_q     <= run_done_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      timer_d        = timer_q;
      rst_cnt_d      = rst_cnt_q;
      done_mask_d    = done_mask_q;
      timeout_mask_d = timeout_mask_q;
      aborted_d      = aborted_q;
      tm_rst_d       = 1'b0;
      cur_task_d     = '0;
      start_d        = 1'b0;
      busy_d         = 1'b0;
      run_done_d     = 1'b0;

      if (abort_ok) begin
         // Abort beats every other transition, including a same-cycle done
         state_d   = S_FINISH;
         aborted_d = 1'b1;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.i_go) begin
                  state_d        = S_SCAN;
                  idx_d          = IDX_W'(1);
                  done_mask_d    = '0;
                  timeout_mask_d = '0;
                  aborted_d      = 1'b0;
               end
            end

            // One index per cycle; enables are read live, not latched at go
            S_SCAN: begin
               if (idx_q > IDX_W'(NUMBER_OF_TASKS)) begin
                  state_d = S_FINISH;
               end else if (bus.i_enabled_tasks[bit_sel]) begin
                  state_d   = S_TM_RESET;
                  rst_cnt_d = '0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end

            S_TM_RESET: begin
               if (rst_cnt_q == RST_W'(TM_RST_CYCLES - 1)) begin
                  state_d = S_START;
               end else begin
                  rst_cnt_d = rst_cnt_q + RST_W'(1);
               end
            end

            S_START: begin
               timer_d = '0;
               state_d = S_WAIT_DONE;
            end

            // Done is checked ahead of the timeout so it wins a tie
            S_WAIT_DONE: begin
               timer_d = timer_q + TIMEOUT_W'(1);
               if (bus.i_tasks_done) begin
                  done_mask_d[bit_sel] = 1'b1;
                  state_d              = S_NEXT;
               end else if (timer_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
                  timeout_mask_d[bit_sel] = 1'b1;
                  state_d                 = S_NEXT;
               end
            end

            S_NEXT: begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = S_SCAN;
            end

            S_FINISH: begin
               state_d = S_IDLE;
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      // Outputs are registered copies of what the next state implies
      tm_rst_d   = (state_d == S_TM_RESET) || (state_d == S_FINISH);
      start_d    = (state_d == S_START);
      busy_d     = (state_d != S_IDLE);
      run_done_d = (state_d == S_FINISH);
      cur_task_d = ((state_d == S_IDLE) || (state_d == S_FINISH)) ? '0 : TASK_W'(idx_d);
   end

   assign bus.o_tm_rst       = tm_rst_q;
   assign bus.o_current_task = cur_task_q;
   assign bus.o_start_tests  = start_q;
   assign bus.o_busy         = busy_q;
   assign bus.o_run_done     = run_done_q;
   assign bus.o_aborted      = aborted_q;
   assign bus.o_done_mask    = done_mask_q;
   assign bus.o_timeout_mask = timeout_mask_q;

endmodule : task_scheduler

// File: tb/tb_task_scheduler.sv
// ----------------------------------------------------------------------------
// tb_task_scheduler
//   Directed bench for task_scheduler. Two instances share one set of inputs:
//   dut_a (TIMEOUT_CYCLES=100) carries the long-task runs, dut_b
//   (TIMEOUT_CYCLES=20) carries the timeout boundary runs.
// ----------------------------------------------------------------------------
module tb_task_scheduler;

   logic        clk;
   logic        rst;
   logic        go;
   logic        abort;
   logic        done;
   logic [31:0] en;

   int n_assert = 0;
   int n_fail   = 0;

   task_scheduler_if ifa ();
   task_scheduler_if ifb ();

   assign ifa.i_go            = go;
   assign ifa.i_abort         = abort;
   assign ifa.i_enabled_tasks = en;
   assign ifa.i_tasks_done    = done;
   assign ifb.i_go            = go;
   assign ifb.i_abort         = abort;
   assign ifb.i_enabled_tasks = en;
   assign ifb.i_tasks_done    = done;

   task_scheduler #(
      .NUMBER_OF_TASKS (16),
      .TM_RST_CYCLES   (4),
      .TIMEOUT_CYCLES  (100),
      .TIMEOUT_W       (7)
   ) dut_a (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (ifa.master)
   );

   task_scheduler #(
      .NUMBER_OF_TASKS (16),
      .TM_RST_CYCLES   (4),
      .TIMEOUT_CYCLES  (20),
      .TIMEOUT_W       (5)
   ) dut_b (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (ifb.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // dut_a event monitor: start pulses, granted task, tm_rst run before each start
   int          start_cnt_a = 0;
   int          rd_cnt_a    = 0;
   int          run_a       = 0;
   int          last_run_a  = 0;
   int          rst_bad_a   = 0;
   logic [31:0] starts_a[$];

   always @(negedge clk) begin
      if (ifa.o_start_tests) begin
         start_cnt_a <= start_cnt_a + 1;
         starts_a.push_back(ifa.o_current_task);
         last_run_a  <= run_a;
         if (run_a != 4) rst_bad_a <= rst_bad_a + 1;
      end
      if (ifa.o_run_done) rd_cnt_a <= rd_cnt_a + 1;
      run_a <= ifa.o_tm_rst ? run_a + 1 : 0;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int cnt;
      int t;
      int base_start;
      int base_rd;
      int base_bad;
      int qbase;
      bit hit;

      rst   = 1'b1;
      go    = 1'b0;
      abort = 1'b0;
      done  = 1'b0;
      en    = 32'h0;
      tick(); tick(); tick();
      rst = 1'b0;
      tick();

      // Reset state
      check("rst_a_busy",     32'(ifa.o_busy),       32'd0);
      check("rst_a_tm_rst",   32'(ifa.o_tm_rst),     32'd0);
      check("rst_a_task",     ifa.o_current_task,    32'd0);
      check("rst_a_start",    32'(ifa.o_start_tests), 32'd0);
      check("rst_a_run_done", 32'(ifa.o_run_done),   32'd0);
      check("rst_a_aborted",  32'(ifa.o_aborted),    32'd0);
      check("rst_a_dmask",    ifa.o_done_mask,       32'd0);
      check("rst_a_tmask",    ifa.o_timeout_mask,    32'd0);
      check("rst_b_busy",     32'(ifb.o_busy),       32'd0);

      // Run 1: tasks 1,6,10, done raised 50 cycles after each start
      base_start = start_cnt_a;
      base_rd    = rd_cnt_a;
      base_bad   = rst_bad_a;
      qbase      = starts_a.size();
      en = 32'h0000_0221;
      go = 1'b1;
      tick();
      go  = 1'b0;
      cnt = 0;
      hit = 1'b0;
      for (int c = 0; c < 3000 && !hit; c++) begin
         tick();
         if (ifa.o_start_tests) cnt = 50;
         else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) done = 1'b1;
         end
         if (ifa.o_tm_rst) done = 1'b0;
         if (ifa.o_run_done) hit = 1'b1;
      end
      check("t1_run_done_seen", 32'(hit), 32'd1);
      tick(); tick();
      check("t1_start_count", 32'(start_cnt_a - base_start), 32'd3);
      check("t1_run_done_cnt", 32'(rd_cnt_a - base_rd), 32'd1);
      check("t1_tm_rst_runs", 32'(rst_bad_a - base_bad), 32'd0);
      if (starts_a.size() >= qbase + 3) begin
         check("t1_task0", starts_a[qbase],     32'd1);
         check("t1_task1", starts_a[qbase + 1], 32'd6);
         check("t1_task2", starts_a[qbase + 2], 32'd10);
      end else begin
         check("t1_start_queue", 32'(starts_a.size() - qbase), 32'd3);
      end
      check("t1_dmask", ifa.o_done_mask,    32'h0000_0221);
      check("t1_tmask", ifa.o_timeout_mask, 32'h0);
      check("t1_busy",  32'(ifa.o_busy),    32'd0);

      // Run 2 (dut_b): task 2 never finishes, 20-cycle timeout
      rst = 1'b1; tick(); rst = 1'b0;
      done = 1'b0;
      en   = 32'h2;
      go   = 1'b1; tick(); go = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 100 && !hit; c++) begin
         tick();
         if (ifb.o_start_tests) hit = 1'b1;
      end
      check("t2_start_seen", 32'(hit), 32'd1);
      check("t2_start_task", ifb.o_current_task, 32'd2);
      t = 0;
      hit = 1'b0;
      for (int c = 0; c < 100 && !hit; c++) begin
         tick();
         t++;
         if (ifb.o_timeout_mask != 32'h0) hit = 1'b1;
      end
      check("t2_wait_done_cycles", 32'(t - 1), 32'd20);
      check("t2_next_keeps_task", ifb.o_current_task, 32'd2);
      check("t2_dmask_mid", ifb.o_done_mask, 32'h0);
      tick();
      check("t2_scan_next_idx", ifb.o_current_task, 32'd3);
      hit = 1'b0;
      for (int c = 0; c < 100 && !hit; c++) begin
         tick();
         if (ifb.o_run_done) hit = 1'b1;
      end
      check("t2_run_done_seen", 32'(hit), 32'd1);
      check("t2_tmask", ifb.o_timeout_mask, 32'h2);
      check("t2_dmask", ifb.o_done_mask,    32'h0);

      // Run 3 (dut_b): done arrives on the last timer cycle, done wins
      rst = 1'b1; tick(); rst = 1'b0;
      en = 32'h1;
      go = 1'b1; tick(); go = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 100 && !hit; c++) begin
         tick();
         if (ifb.o_start_tests) hit = 1'b1;
      end
      check("t3_start_seen", 32'(hit), 32'd1);
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (c == 20) done = 1'b1;
      end
      tick();
      done = 1'b0;
      check("t3_dmask", ifb.o_done_mask,    32'h1);
      check("t3_tmask", ifb.o_timeout_mask, 32'h0);

      // Run 4 (dut_a): abort during task 2 WAIT_DONE
      rst = 1'b1; tick(); rst = 1'b0;
      en = 32'h3;
      go = 1'b1; tick(); go = 1'b0;
      cnt = 0;
      hit = 1'b0;
      for (int c = 0; c < 200 && !hit; c++) begin
         tick();
         if (ifa.o_start_tests && ifa.o_current_task == 32'd2) hit = 1'b1;
         else if (ifa.o_start_tests) cnt = 5;
         else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) done = 1'b1;
         end
         if (ifa.o_tm_rst) done = 1'b0;
      end
      check("t4_task2_start", 32'(hit), 32'd1);
      done = 1'b0;
      tick(); tick(); tick();
      check("t4_task_before_abort", ifa.o_current_task, 32'd2);
      abort = 1'b1; tick(); abort = 1'b0;
      check("t4_run_done",  32'(ifa.o_run_done), 32'd1);
      check("t4_aborted",   32'(ifa.o_aborted),  32'd1);
      check("t4_tm_rst",    32'(ifa.o_tm_rst),   32'd1);
      check("t4_dmask",     ifa.o_done_mask,     32'h1);
      check("t4_tmask",     ifa.o_timeout_mask,  32'h0);
      tick();
      check("t4_run_done_end", 32'(ifa.o_run_done), 32'd0);
      check("t4_task_after",   ifa.o_current_task,  32'd0);
      check("t4_busy_after",   32'(ifa.o_busy),     32'd0);
      check("t4_aborted_held", 32'(ifa.o_aborted),  32'd1);

      // Run 5 (dut_a): nothing enabled, go clears o_aborted
      base_start = start_cnt_a;
      en = 32'h0;
      go = 1'b1; tick(); go = 1'b0;
      check("t5_aborted_clr", 32'(ifa.o_aborted), 32'd0);
      check("t5_busy",        32'(ifa.o_busy),    32'd1);
      check("t5_first_idx",   ifa.o_current_task, 32'd1);
      t = 0;
      hit = 1'b0;
      for (int c = 0; c < 100 && !hit; c++) begin
         tick();
         t++;
         if (ifa.o_run_done) hit = 1'b1;
      end
      check("t5_run_done_latency", 32'(t + 1), 32'd18);
      check("t5_no_start", 32'(start_cnt_a - base_start), 32'd0);
      check("t5_dmask", ifa.o_done_mask,    32'h0);
      check("t5_tmask", ifa.o_timeout_mask, 32'h0);

      // Run 6 (dut_a): stale done, go while busy, reset mid TM_RESET
      done = 1'b1;
      rst = 1'b1; tick(); rst = 1'b0;
      tick();
      en = 32'h1;
      go = 1'b1; tick(); go = 1'b0;
      check("t6_dmask_scan", ifa.o_done_mask, 32'h0);
      tick();
      check("t6_tm_rst_on", 32'(ifa.o_tm_rst), 32'd1);
      tick();
      go = 1'b1; tick(); go = 1'b0;
      check("t6_task_stable", ifa.o_current_task, 32'd1);
      hit = 1'b0;
      for (int c = 0; c < 20 && !hit; c++) begin
         tick();
         if (ifa.o_start_tests) hit = 1'b1;
      end
      check("t6_start_seen", 32'(hit), 32'd1);
      check("t6_dmask_start", ifa.o_done_mask, 32'h0);
      tick();
      check("t6_tm_rst_run", 32'(last_run_a), 32'd4);
      check("t6_dmask_wait", ifa.o_done_mask, 32'h0);
      tick();
      check("t6_dmask_next", ifa.o_done_mask, 32'h1);
      done = 1'b0;
      hit = 1'b0;
      for (int c = 0; c < 100 && !hit; c++) begin
         tick();
         if (ifa.o_run_done) hit = 1'b1;
      end
      check("t6_run_done_seen", 32'(hit), 32'd1);
      tick();
      go = 1'b1; tick(); go = 1'b0;
      tick(); tick();
      check("t6_mid_tm_rst", 32'(ifa.o_tm_rst), 32'd1);
      rst = 1'b1; tick(); rst = 1'b0;
      check("t6_rst_tm_rst",   32'(ifa.o_tm_rst),      32'd0);
      check("t6_rst_task",     ifa.o_current_task,     32'd0);
      check("t6_rst_busy",     32'(ifa.o_busy),        32'd0);
      check("t6_rst_start",    32'(ifa.o_start_tests), 32'd0);
      check("t6_rst_run_done", 32'(ifa.o_run_done),    32'd0);
      check("t6_rst_dmask",    ifa.o_done_mask,        32'h0);
      tick();
      check("t6_idle_after",   32'(ifa.o_busy),        32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_task_scheduler
